// File: rtl/gf2_poly_divider_if.sv
// Request/result bundle for gf2_poly_divider: dividend/divisor in, quotient/remainder out.
interface gf2_poly_divider_if #(
   parameter int N = 571
);
   logic             start;
   logic [2*N-1:0]   a;
   logic [N-1:0]     b;
   logic [2*N-1:0]   q;
   logic [N-1:0]     r;
   logic             busy;
   logic             done;
   logic             div_zero;

   modport master (output start, a, b, input  q, r, busy, done, div_zero);
   modport slave  (input  start, a, b, output q, r, busy, done, div_zero);
endinterface

// File: rtl/gf2_poly_divider.sv
// Bit-serial GF(2) long divider: A = Q*B ^ R, deg R < deg B.
// GF2_DIV_QUOTIENT_EN keeps the quotient register; without it the block only reduces (q = 0).
module gf2_poly_divider #(
   parameter int N = 571
) (
   input  logic               clk,
   input  logic               rst,
   gf2_poly_divider_if.slave  bus
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(2*N + 1);

   typedef enum logic [1:0] {IDLE, SCAN, DIV, DONE} state_t;

   state_t          state;
   logic [2*N-1:0]  a_reg;
   logic [N-1:0]    b_reg;
   logic [N-1:0]    r_reg;
   logic [IW-1:0]   idx;
   logic [IW-1:0]   d;
   logic [CW-1:0]   cnt;
   logic [N-1:0]    r_out;
   logic            busy_q;
   logic            done_q;
   logic            dz_q;

   logic [N-1:0]    t_sh;
   logic [N-1:0]    t_nx;
   logic            qb;

`ifdef GF2_DIV_QUOTIENT_EN
   logic [2*N-1:0]  q_reg;
   logic [2*N-1:0]  q_out;
   logic [2*N-1:0]  q_nx;
   assign q_nx  = {q_reg[2*N-2:0], qb};
   assign bus.q = q_out;
`else
   assign bus.q = '0;
`endif

   // Bring in the next dividend bit; since deg R < d, t has degree <= d.
   always_comb begin
      t_sh = {r_reg[N-2:0], a_reg[2*N-1]};
      qb   = t_sh[d];
      t_nx = qb ? (t_sh ^ b_reg) : t_sh;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         a_reg  <= '0;
         b_reg  <= '0;
         r_reg  <= '0;
         idx    <= '0;
         d      <= '0;
         cnt    <= '0;
         r_out  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         dz_q   <= 1'b0;
`ifdef GF2_DIV_QUOTIENT_EN
         q_reg  <= '0;
         q_out  <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               a_reg <= bus.a;
               b_reg <= bus.b;
               r_reg <= '0;
               dz_q  <= 1'b0;
               idx   <= IW'(N-1);
               cnt   <= '0;
`ifdef GF2_DIV_QUOTIENT_EN
               q_reg <= '0;
`endif
               if (bus.b == '0) begin
                  state <= DONE;
               end else begin
                  state  <= SCAN;
                  busy_q <= 1'b1;
               end
            end
            SCAN: begin
               if (b_reg[idx]) begin
                  d     <= idx;
                  cnt   <= '0;
                  state <= DIV;
               end else begin
                  idx <= idx - IW'(1);
               end
            end
            DIV: begin
               a_reg <= a_reg << 1;
               r_reg <= t_nx;
               cnt   <= cnt + CW'(1);
`ifdef GF2_DIV_QUOTIENT_EN
               q_reg <= q_nx;
`endif
               if (cnt == CW'(2*N-1)) begin
                  r_out  <= t_nx;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= DONE;
`ifdef GF2_DIV_QUOTIENT_EN
                  q_out  <= q_nx;
`endif
               end
            end
            DONE: begin
               // Entering with done low means a zero divisor: publish the zero result now.
               if (done_q) begin
                  done_q <= 1'b0;
                  state  <= IDLE;
               end else begin
                  done_q <= 1'b1;
                  dz_q   <= 1'b1;
                  r_out  <= '0;
`ifdef GF2_DIV_QUOTIENT_EN
                  q_out  <= '0;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.r        = r_out;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_gf2_poly_divider.sv
// Bench for gf2_poly_divider: an N=8 instance for directed vectors and an N=571 instance for
// multiplier cross-checks, both compared each cycle against a textbook long-division model.
module tb_gf2_poly_divider;
   localparam int SN = 8;
   localparam int BN = 571;
   localparam int W2 = 2*BN;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   gf2_poly_divider_if #(.N(SN)) sif ();
   gf2_poly_divider_if #(.N(BN)) bif ();

   gf2_poly_divider #(.N(SN)) u_small (.clk(clk), .rst(rst), .bus(sif));
   gf2_poly_divider #(.N(BN)) u_big   (.clk(clk), .rst(rst), .bus(bif));

   task automatic chk(input string nm, input logic [W2-1:0] act, input logic [W2-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %h want %h (low 128 bits)", nm, cyc, act[127:0], exp[127:0]);
      end
   endtask

   // Textbook long division: cancel the top set bit with a shifted copy of b.
   function automatic void ref_div(input int n, input logic [W2-1:0] a, input logic [W2-1:0] b,
                                   output logic [W2-1:0] q, output logic [W2-1:0] r, output int d);
      logic [W2-1:0] rem;
      rem = a;
      q   = '0;
      r   = '0;
      d   = -1;
      for (int i = n-1; i >= 0; i--) if (b[i] && d < 0) d = i;
      if (d < 0) return;
      for (int i = 2*n-1; i >= d; i--)
         if (rem[i]) begin
            q[i-d] = 1'b1;
            rem    = rem ^ (b << (i-d));
         end
      r = rem;
   endfunction

   function automatic logic [W2-1:0] clmul(input logic [W2-1:0] x, input logic [W2-1:0] y, input int n);
      logic [W2-1:0] p;
      p = '0;
      for (int i = 0; i < n; i++) if (y[i]) p = p ^ (x << i);
      return p;
   endfunction

   function automatic logic [W2-1:0] rnd(input int nbits);
      logic [W2-1:0] v;
      v = '0;
      for (int i = 0; i < nbits; i++) v[i] = 1'($urandom_range(0, 1));
      return v;
   endfunction

   // Expected state of the small instance
   bit              s_act = 0;
   bit              s_bnz = 0;
   int              s_t0 = 0;
   int              s_L = 0;
   logic [2*SN-1:0] s_nq = '0, cur_q = '0;
   logic [SN-1:0]   s_nr = '0, cur_r = '0;
   logic            s_ndz = 0, cur_dz = 0;
   // Expected state of the big instance
   bit              bg_act = 0;
   int              bg_t0 = 0;
   int              bg_L = 0;
   logic [W2-1:0]   bg_a = '0, bg_b = '0, bg_nq = '0, bg_nr = '0;
   logic            bg_ndz = 0, bg_dz = 0;

   always @(negedge clk) begin
      logic in_op, dexp, bdexp;
      #2;
      if (!rst) begin
         chk("rst.q", sif.q, '0);
         chk("rst.r", sif.r, '0);
         chk("rst.busy", sif.busy, '0);
         chk("rst.done", sif.done, '0);
         chk("rst.dz", sif.div_zero, '0);
         chk("rst.big_done", bif.done, '0);
         chk("rst.big_busy", bif.busy, '0);
         s_act = 0; cur_q = '0; cur_r = '0; cur_dz = 0;
         bg_act = 0; bg_dz = 0;
      end else begin
         in_op = s_act && cyc >= s_t0 && cyc < s_t0 + s_L;
         dexp  = s_act && cyc == s_t0 + s_L;
         if (dexp) begin
            cur_q = s_nq; cur_r = s_nr; cur_dz = s_ndz; s_act = 0;
         end
         chk("s.done", sif.done, dexp);
         chk("s.busy", sif.busy, in_op && s_bnz);
         chk("s.q", sif.q, cur_q);
         chk("s.r", sif.r, cur_r);
         chk("s.dz", sif.div_zero, in_op ? 1'b0 : cur_dz);

         bdexp = bg_act && cyc == bg_t0 + bg_L;
         chk("b.done", bif.done, bdexp);
         if (bg_act && cyc >= bg_t0 && cyc < bg_t0 + bg_L) bg_dz = 0;
         if (bdexp) begin
            bg_act = 0;
            bg_dz  = bg_ndz;
            chk("b.q", bif.q, bg_nq);
            chk("b.r", bif.r, bg_nr);
`ifdef GF2_DIV_QUOTIENT_EN
            chk("b.qb^r", clmul(bif.q, bg_b, BN) ^ W2'(bif.r), bg_a);
`endif
         end
         chk("b.dz", bif.div_zero, bg_dz);
      end
   end

   task automatic run_op(input logic [2*SN-1:0] a, input logic [SN-1:0] b, input bit hold, input int abort_at);
      logic [W2-1:0] mq, mr;
      int d;
      ref_div(SN, W2'(a), W2'(b), mq, mr, d);
      sif.a = a; sif.b = b; sif.start = 1'b1;
      s_t0  = cyc + 1;
      s_bnz = (b != '0);
      s_L   = (b == '0) ? 1 : (SN - d) + 2*SN;
`ifdef GF2_DIV_QUOTIENT_EN
      s_nq  = mq[2*SN-1:0];
`else
      s_nq  = '0;
`endif
      s_nr  = mr[SN-1:0];
      s_ndz = (b == '0);
      s_act = 1;
      if (!hold) begin @(negedge clk); sif.start = 1'b0; end
      while (cyc < s_t0 + s_L) begin
         if (abort_at > 0 && cyc == s_t0 + abort_at) begin
            sif.start = 1'b0;
            rst = 1'b0;
            repeat (2) @(negedge clk);
            rst = 1'b1;
            repeat (3) @(negedge clk);
            return;
         end
         @(negedge clk);
      end
      sif.start = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_big(input logic [W2-1:0] a, input logic [W2-1:0] b);
      logic [W2-1:0] mq, mr;
      int d;
      ref_div(BN, a, b, mq, mr, d);
      bif.a = a; bif.b = b[BN-1:0]; bif.start = 1'b1;
      bg_a  = a; bg_b = b;
      bg_t0 = cyc + 1;
      bg_L  = (d < 0) ? 1 : (BN - d) + 2*BN;
`ifdef GF2_DIV_QUOTIENT_EN
      bg_nq = mq;
`else
      bg_nq = '0;
`endif
      bg_nr  = mr;
      bg_ndz = (d < 0);
      bg_act = 1;
      @(negedge clk);
      bif.start = 1'b0;
      while (cyc < bg_t0 + bg_L) @(negedge clk);
      @(negedge clk);
   endtask

   logic [15:0] ta [5] = '{16'h000F, 16'h0010, 16'hFFFF, 16'h1234, 16'h8000};
   logic [7:0]  tb [5] = '{8'h03,    8'h13,    8'h01,    8'h00,    8'h80};
   logic [15:0] tq [5] = '{16'h0005, 16'h0001, 16'hFFFF, 16'h0000, 16'h0100};
   logic [7:0]  tr [5] = '{8'h00,    8'h03,    8'h00,    8'h00,    8'h00};
   int          td [5] = '{1,        4,        0,        -1,       7};
   int          tl [5] = '{23,       20,       24,       1,        17};

   initial begin
      logic [W2-1:0] mq, mr, x, y;
      int d;
      sif.start = 1'b0; sif.a = '0; sif.b = '0;
      bif.start = 1'b0; bif.a = '0; bif.b = '0;
      repeat (4) begin @(negedge clk); sif.start = ~sif.start; end
      sif.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // Pin the model and the latency formula to hand-worked answers, then run them on the DUT.
      for (int i = 0; i < 5; i++) begin
         ref_div(SN, W2'(ta[i]), W2'(tb[i]), mq, mr, d);
         chk("model.q", mq, W2'(tq[i]));
         chk("model.r", mr, W2'(tr[i]));
         chk("model.d", W2'(d), W2'(td[i]));
         chk("model.lat", W2'((d < 0) ? 1 : (SN - d) + 2*SN), W2'(tl[i]));
         run_op(ta[i], tb[i], 1'b0, 0);
      end
      // Valid start after the zero divisor must clear div_zero.
      run_op(16'h0ABC, 8'h0B, 1'b0, 0);
      run_op(16'h0000, 8'h00, 1'b0, 0);
      run_op(16'h0010, 8'h13, 1'b0, 0);
      // start held through the whole operation yields one done.
      run_op(16'hBEEF, 8'h1D, 1'b1, 0);
      repeat (4) @(negedge clk);
      // Reset landing in the DIV phase (SCAN takes 7 cycles for b=03).
      run_op(16'h000F, 8'h03, 1'b0, 12);
      for (int i = 0; i < 4; i++)
         run_op(16'($urandom), 8'($urandom_range(1, 255)), 1'b0, 0);

      // Cross-check against multiplier products at full width.
      for (int k = 0; k < 2; k++) begin
         x = rnd(BN);
         y = rnd(BN);
         if (y == '0) y = W2'(1);
         ref_div(BN, clmul(x, y, BN), y, mq, mr, d);
         chk("model.xy.q", mq, x);
         chk("model.xy.r", mr, '0);
         run_big(clmul(x, y, BN), y);
      end
      x = rnd(W2);
      y = rnd(BN);
      ref_div(BN, x, y, mq, mr, d);
      chk("model.qb^r", clmul(mq, y, BN) ^ mr, x);
      run_big(x, y);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end
endmodule
